// File: rtl/tx_drv_slice_ramp.sv
// Slice-enable ramp controller for the differential TX output driver.
// Converts binary N/P strength codes into thermometer output-enables and
// walks the enabled count one slice per STEP_CYC cycles so the driver
// impedance never jumps. Dropping en ramps both sides softly down to zero.
//
// Handshake: load is a single-cycle strobe with no ready; tgt_n/tgt_p are
// sampled on any edge where load=1. done is a one-cycle completion pulse.
// busy is the FSM state itself (1 = RAMP), so it doubles as the debug view.
module tx_drv_slice_ramp #(
   parameter int N_SLICE  = 16,
   parameter int STEP_CYC = 4,
   parameter int CODE_W   = $clog2(N_SLICE + 1)
) (
   input  logic              clk,
   input  logic              rstb,
   input  logic              en,
   input  logic              load,
   input  logic [CODE_W-1:0] tgt_n,
   input  logic [CODE_W-1:0] tgt_p,
   output logic [N_SLICE-1:0] ctl_slice_n,
   output logic [N_SLICE-1:0] ctl_slice_p,
   output logic [CODE_W-1:0] cur_n,
   output logic [CODE_W-1:0] cur_p,
   output logic              busy,
   output logic              done
);

   localparam int CNT_W = (STEP_CYC > 1) ? $clog2(STEP_CYC) : 1;

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] RAMP = 1'b1;

   localparam logic [CODE_W-1:0] CODE_MAX = CODE_W'(N_SLICE);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(STEP_CYC - 1);

   logic [0:0]         state, state_nxt;
   logic [CNT_W-1:0]   cnt, cnt_nxt;
   logic [CODE_W-1:0]  cur_n_q, cur_p_q, cur_n_nxt, cur_p_nxt;
   logic [CODE_W-1:0]  lt_n, lt_p;
   logic [CODE_W-1:0]  eff_n, eff_p;
   logic [N_SLICE-1:0] ctl_n_q, ctl_p_q;
   logic               done_q, done_nxt;
   logic               load_d;

   // Move a count one slice toward its goal, or hold when already there.
   function automatic logic [CODE_W-1:0] step_toward(input logic [CODE_W-1:0] c,
                                                     input logic [CODE_W-1:0] e);
      logic [CODE_W-1:0] r;
      r = c;
      if (c < e)      r = c + CODE_W'(1);
      else if (c > e) r = c - CODE_W'(1);
      return r;
   endfunction

   // Thermometer expansion: slice i is on when i < count.
   function automatic logic [N_SLICE-1:0] therm(input logic [CODE_W-1:0] c);
      logic [N_SLICE-1:0] t;
      t = '0;
      for (int i = 0; i < N_SLICE; i++) t[i] = (c > CODE_W'(i));
      return t;
   endfunction

   // Requested codes above the slice count clamp to all slices on.
   function automatic logic [CODE_W-1:0] sat(input logic [CODE_W-1:0] t);
      return (t > CODE_MAX) ? CODE_MAX : t;
   endfunction

   assign eff_n = en ? lt_n : '0;
   assign eff_p = en ? lt_p : '0;

   // Next-state: start a ramp on any mismatch, step on the last counter phase,
   // and return to IDLE with done once both sides sit on the effective target.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      cur_n_nxt = cur_n_q;
      cur_p_nxt = cur_p_q;
      done_nxt  = 1'b0;
      case (state)
         IDLE: begin
            if ((cur_n_q != eff_n) || (cur_p_q != eff_p)) begin
               state_nxt = RAMP;
               cnt_nxt   = '0;
            end else if (load_d) begin
               // A load that asks for what is already applied completes at once.
               done_nxt = 1'b1;
            end
         end
         RAMP: begin
            if (cnt == CNT_LAST) begin
               cnt_nxt   = '0;
               cur_n_nxt = step_toward(cur_n_q, eff_n);
               cur_p_nxt = step_toward(cur_p_q, eff_p);
               if ((cur_n_nxt == eff_n) && (cur_p_nxt == eff_p)) begin
                  state_nxt = IDLE;
                  done_nxt  = 1'b1;
               end
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State, counts and registered slice enables; reset drops all slices at once.
   always_ff @(posedge clk) begin
      if (!rstb) begin
         state   <= IDLE;
         cnt     <= '0;
         cur_n_q <= '0;
         cur_p_q <= '0;
         lt_n    <= '0;
         lt_p    <= '0;
         ctl_n_q <= '0;
         ctl_p_q <= '0;
         done_q  <= 1'b0;
         load_d  <= 1'b0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         cur_n_q <= cur_n_nxt;
         cur_p_q <= cur_p_nxt;
         ctl_n_q <= therm(cur_n_nxt);
         ctl_p_q <= therm(cur_p_nxt);
         done_q  <= done_nxt;
         load_d  <= load;
         if (load) begin
            lt_n <= sat(tgt_n);
            lt_p <= sat(tgt_p);
         end
      end
   end

   assign ctl_slice_n = ctl_n_q;
   assign ctl_slice_p = ctl_p_q;
   assign cur_n       = cur_n_q;
   assign cur_p       = cur_p_q;
   assign busy        = (state == RAMP);
   assign done        = done_q;

endmodule
